iod_dly_tap_ctrl: RTL and testbench
===================================

Name: iod_dly_tap_ctrl

Overview:
Sequencer for one IOD dynamic delay line (DELAY_LINE_MOVE/DIRECTION/LOAD, OUT_OF_RANGE). It accepts tap commands from the training/calibration logic and converts them into correctly spaced single-tap move pulses or a load pulse. It tracks the current tap and reports completion and errors. There is one instance per IOD lane, in the FAB_CLK domain, beside the DDR PHY lane IODs.

Parameters:
TAP_W, 8, width of tap counter and command argument.
MAX_TAP, 255, highest legal tap index (0..MAX_TAP).
LOAD_TAP, 1, tap value the IOD takes on DELAY_LINE_LOAD (matches static TX/RX_DELAY_VAL).
MOVE_GAP, 4, settle cycles after each MOVE or LOAD pulse before the next action (>=1).

Ports:
FAB_CLK  in  1  fabric clock; all logic rising-edge.
SYNC_RST  in  1  synchronous active-high reset.
CMD_VALID  in  1  command request.
CMD_READY  out  1  controller idle and accepting.
CMD_OP  in  2  00=load default, 01=increment by ARG, 10=decrement by ARG, 11=goto absolute ARG.
CMD_ARG  in  TAP_W  step count or absolute tap.
BUSY  out  1  command in progress (state != IDLE).
DONE  out  1  one-cycle completion pulse.
ERR  out  1  one-cycle, coincident with DONE; saturation or out-of-range.
CUR_TAP  out  TAP_W  current tracked tap.
DELAY_LINE_MOVE  out  1  one-cycle move pulse to IOD.
DELAY_LINE_DIRECTION  out  1  1=increase delay, 0=decrease.
DELAY_LINE_LOAD  out  1  one-cycle load pulse to IOD.
DELAY_LINE_OUT_OF_RANGE  in  1  IOD range flag.

Behaviour:
- Reset (SYNC_RST high at edge): state=INIT_LOAD, CUR_TAP=LOAD_TAP, all pulses 0, DIRECTION=0, CMD_READY=0, BUSY=1, DONE=0, ERR=0.
- After reset: automatic LOAD (LOAD=1 one cycle), MOVE_GAP settle, then IDLE. No DONE pulse for the auto-load.
- States: INIT_LOAD, IDLE, SETUP, MOVE, GAP, LOAD, LGAP, FIN.
- IDLE: CMD_READY=1. Handshake on VALID&READY. CMD_OP and CMD_ARG are captured at that edge and are ignored afterwards.
- Target computation uses TAP_W+1-bit arithmetic:
  - inc: target = min(CUR+ARG, MAX_TAP).
  - dec: target = max(CUR-ARG, 0).
  - goto: target = min(ARG, MAX_TAP).
  - Clamping sets a sticky sat flag.
- Op 00 → LOAD (LOAD=1 one cycle) → LGAP (MOVE_GAP cycles) → FIN. CUR_TAP=LOAD_TAP, written in the LOAD cycle.
- Other ops → SETUP, one cycle. DIRECTION = (target > CUR) is driven and then held until FIN. If target == CUR, go directly to FIN.
- MOVE: MOVE=1 for one cycle. CUR_TAP ±1 at the end of that cycle. Then GAP.
- GAP: MOVE_GAP cycles. If OUT_OF_RANGE is sampled high in any GAP cycle:
  - CUR_TAP reverts to its pre-move value.
  - At GAP end, go to FIN with the error flag set.
  - Otherwise at GAP end: if CUR == target go to FIN, else go to MOVE.
- Move period = 1+MOVE_GAP cycles.
- FIN: DONE=1 for one cycle, ERR = sat | oor. Next cycle IDLE. Flags clear on the next accept.
- Latency for inc by N (N moves, no clamp), accept at cycle 0:
  - SETUP c1, first MOVE c2.
  - DONE at c(2 + N·(1+MOVE_GAP)).
  - CMD_READY returns one cycle later.
- MOVE and LOAD are never high together. MOVE and LOAD are never issued with fewer than MOVE_GAP idle cycles between pulses.
- OUT_OF_RANGE outside GAP/LGAP is ignored.
- SYNC_RST mid-command: abort immediately, no DONE, restart at INIT_LOAD.
- CMD_VALID while busy: not accepted (READY=0). The requester must hold VALID.

Test Plan:
- Reset release with MOVE_GAP=4 → LOAD pulse on the first cycle after reset, CUR_TAP=1, CMD_READY=1 after 4 gap cycles, no DONE.
- From tap 1, inc ARG=3 accepted at c0:
  - DIRECTION=1 from c1.
  - MOVE at c2, c7, c12.
  - DONE at c17 with ERR=0, CUR_TAP=4.
- CUR_TAP=4, dec ARG=10 → 4 MOVE pulses with DIRECTION=0, CUR_TAP=0, DONE with ERR=1.
- CUR_TAP=250, goto 255 (MAX_TAP=255), OUT_OF_RANGE asserted in GAP after the 3rd move → CUR_TAP=252 (reverted), DONE with ERR=1, no 4th MOVE.
- goto 0 from tap 0 → SETUP then FIN: DONE at c2, no MOVE, ERR=0. Op 00 from tap 40 → LOAD pulse, DONE after LGAP, CUR_TAP=1.
- SYNC_RST asserted during the 2nd GAP of a 5-step inc → no DONE, auto LOAD, CUR_TAP=1; a new command is accepted normally afterwards.

Source files
------------

// File: rtl/iod_dly_tap_ctrl.sv
// IOD dynamic delay-line sequencer: turns tap commands into spaced MOVE/LOAD pulses and tracks the tap.
// Latency: accept->SETUP 1 cycle, then (1+MOVE_GAP) cycles per tap moved; DONE one cycle after the last gap.
// Backpressure: CMD_READY is high only in IDLE; the requester holds CMD_VALID until accepted.
module iod_dly_tap_ctrl #(
    parameter int TAP_W    = 8,
    parameter int MAX_TAP  = 255,
    parameter int LOAD_TAP = 1,
    parameter int MOVE_GAP = 4
) (
    input  logic             FAB_CLK,
    input  logic             SYNC_RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [TAP_W-1:0] CMD_ARG,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [TAP_W-1:0] CUR_TAP,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    input  logic             DELAY_LINE_OUT_OF_RANGE
);

    localparam int               GC_W     = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
    localparam logic [TAP_W:0]   MAX_EXT  = (TAP_W+1)'(MAX_TAP);
    localparam logic [TAP_W-1:0] MAX_T    = TAP_W'(MAX_TAP);
    localparam logic [GC_W-1:0]  GAP_LAST = GC_W'(MOVE_GAP - 1);

    typedef enum logic [2:0] {
        S_INIT_LOAD, S_IDLE, S_SETUP, S_MOVE, S_GAP, S_LOAD, S_LGAP, S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
    logic [TAP_W-1:0] prev_tap_q, prev_tap_d;
    logic [TAP_W-1:0] target_q, target_d;
    logic [GC_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic             dir_q, dir_d;
    logic             sat_q, sat_d;
    logic             oor_q, oor_d;
    logic             init_q, init_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             move_q, move_d;
    logic             load_q, load_d;

    logic [TAP_W:0]   sum_ext, arg_ext;
    logic [TAP_W-1:0] calc_tgt;
    logic             calc_sat;

    // Target is evaluated with one extra bit so overflow/underflow is visible before clamping.
    always_comb begin
        sum_ext  = {1'b0, cur_tap_q} + {1'b0, CMD_ARG};
        arg_ext  = {1'b0, CMD_ARG};
        calc_tgt = cur_tap_q;
        calc_sat = 1'b0;
        case (CMD_OP)
            2'b01: begin
                if (sum_ext > MAX_EXT) begin
                    calc_tgt = MAX_T;
                    calc_sat = 1'b1;
                end else begin
                    calc_tgt = sum_ext[TAP_W-1:0];
                end
            end
            2'b10: begin
                if (arg_ext > {1'b0, cur_tap_q}) begin
                    calc_tgt = '0;
                    calc_sat = 1'b1;
                end else begin
                    calc_tgt = cur_tap_q - CMD_ARG;
                end
            end
            2'b11: begin
                if (arg_ext > MAX_EXT) begin
                    calc_tgt = MAX_T;
                    calc_sat = 1'b1;
                end else begin
                    calc_tgt = CMD_ARG;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cur_tap_d  = cur_tap_q;
        prev_tap_d = prev_tap_q;
        target_d   = target_q;
        gap_cnt_d  = gap_cnt_q;
        dir_d      = dir_q;
        sat_d      = sat_q;
        oor_d      = oor_q;
        init_d     = init_q;
        case (state_q)
            S_INIT_LOAD: begin
                init_d  = 1'b1;
                state_d = S_LOAD;
            end
            S_IDLE: begin
                if (CMD_VALID) begin
                    init_d = 1'b0;
                    oor_d  = 1'b0;
                    sat_d  = 1'b0;
                    if (CMD_OP == 2'b00) begin
                        state_d = S_LOAD;
                    end else begin
                        target_d = calc_tgt;
                        sat_d    = calc_sat;
                        dir_d    = (calc_tgt > cur_tap_q);
                        state_d  = S_SETUP;
                    end
                end
            end
            S_SETUP: state_d = (target_q == cur_tap_q) ? S_FIN : S_MOVE;
            S_MOVE: begin
                prev_tap_d = cur_tap_q;
                cur_tap_d  = dir_q ? cur_tap_q + TAP_W'(1) : cur_tap_q - TAP_W'(1);
                gap_cnt_d  = GAP_LAST;
                state_d    = S_GAP;
            end
            S_GAP: begin
                // The IOD refused the step: the tracked tap must not count it.
                if (DELAY_LINE_OUT_OF_RANGE) begin
                    oor_d     = 1'b1;
                    cur_tap_d = prev_tap_q;
                end
                if (gap_cnt_q == '0) begin
                    state_d = (oor_d || cur_tap_q == target_q) ? S_FIN : S_MOVE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GC_W'(1);
                end
            end
            S_LOAD: begin
                cur_tap_d = TAP_W'(LOAD_TAP);
                gap_cnt_d = GAP_LAST;
                state_d   = S_LGAP;
            end
            S_LGAP: begin
                if (DELAY_LINE_OUT_OF_RANGE && !init_q) oor_d = 1'b1;
                if (gap_cnt_q == '0) begin
                    state_d = init_q ? S_IDLE : S_FIN;
                end else begin
                    gap_cnt_d = gap_cnt_q - GC_W'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_INIT_LOAD;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FIN);
        err_d       = (state_d == S_FIN) && (sat_d || oor_d);
        move_d      = (state_d == S_MOVE);
        load_d      = (state_d == S_LOAD);
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state_q     <= S_INIT_LOAD;
            cur_tap_q   <= TAP_W'(LOAD_TAP);
            prev_tap_q  <= TAP_W'(LOAD_TAP);
            target_q    <= '0;
            gap_cnt_q   <= '0;
            dir_q       <= 1'b0;
            sat_q       <= 1'b0;
            oor_q       <= 1'b0;
            init_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            move_q      <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_tap_q   <= cur_tap_d;
            prev_tap_q  <= prev_tap_d;
            target_q    <= target_d;
            gap_cnt_q   <= gap_cnt_d;
            dir_q       <= dir_d;
            sat_q       <= sat_d;
            oor_q       <= oor_d;
            init_q      <= init_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            move_q      <= move_d;
            load_q      <= load_d;
        end
    end

    assign CMD_READY            = cmd_ready_q;
    assign BUSY                 = busy_q;
    assign DONE                 = done_q;
    assign ERR                  = err_q;
    assign CUR_TAP              = cur_tap_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_LOAD      = load_q;

endmodule

// File: tb/tb_iod_dly_tap_ctrl.sv
// Bench for iod_dly_tap_ctrl: directed scenarios plus random commands against a transaction-level tap model.
module tb_iod_dly_tap_ctrl;

    localparam int TAP_W    = 8;
    localparam int MAX_TAP  = 255;
    localparam int LOAD_TAP = 1;
    localparam int MOVE_GAP = 4;
    localparam int PER      = MOVE_GAP + 1;

    logic             fab_clk = 1'b0;
    logic             sync_rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [TAP_W-1:0] cmd_arg = '0;
    logic             busy, done, err;
    logic [TAP_W-1:0] cur_tap;
    logic             dly_move, dly_dir, dly_load;
    logic             oor = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int mdl_tap = LOAD_TAP;
    int cyc = 0;
    int last_pulse = 0;
    bit lp_vld = 1'b0;
    int overlap_cnt = 0;
    int spacing_bad = 0;

    iod_dly_tap_ctrl #(
        .TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .LOAD_TAP(LOAD_TAP), .MOVE_GAP(MOVE_GAP)
    ) dut (
        .FAB_CLK(fab_clk), .SYNC_RST(sync_rst),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op), .CMD_ARG(cmd_arg),
        .BUSY(busy), .DONE(done), .ERR(err), .CUR_TAP(cur_tap),
        .DELAY_LINE_MOVE(dly_move), .DELAY_LINE_DIRECTION(dly_dir),
        .DELAY_LINE_LOAD(dly_load), .DELAY_LINE_OUT_OF_RANGE(oor)
    );

    always #5 fab_clk = ~fab_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Pulse hygiene: MOVE/LOAD never together and at least MOVE_GAP quiet cycles between pulses.
    always @(negedge fab_clk) begin
        cyc++;
        if (sync_rst) lp_vld = 1'b0;
        else if (dly_move || dly_load) begin
            if (dly_move && dly_load) overlap_cnt++;
            if (lp_vld && (cyc - last_pulse) < PER) spacing_bad++;
            last_pulse = cyc;
            lp_vld = 1'b1;
        end
    end

    // Transaction-level expectation for one command issued from tap 'cur'.
    task automatic model(input int cur, input int op, input int arg, input int oor_k,
                         output int e_tap, output int e_mv, output int e_done,
                         output int e_err, output int e_dir);
        int t, n;
        bit sat;
        sat = 1'b0;
        if (op == 0) begin
            e_tap = LOAD_TAP; e_mv = 0; e_done = 2 + MOVE_GAP; e_err = 0; e_dir = 0;
            return;
        end
        t = (op == 1) ? cur + arg : (op == 2) ? cur - arg : arg;
        if (t > MAX_TAP) begin t = MAX_TAP; sat = 1'b1; end
        if (t < 0)       begin t = 0;       sat = 1'b1; end
        n     = (t > cur) ? t - cur : cur - t;
        e_dir = (t > cur) ? 1 : 0;
        if (oor_k >= 1 && oor_k <= n) begin
            e_mv  = oor_k;
            e_tap = e_dir ? cur + oor_k - 1 : cur - oor_k + 1;
            e_err = 1;
        end else begin
            e_mv  = n;
            e_tap = t;
            e_err = sat ? 1 : 0;
        end
        e_done = 2 + e_mv * PER;
    endtask

    task automatic do_reset(input int n);
        int ld_t, rdy_t, dn;
        sync_rst = 1'b1; cmd_valid = 1'b0; oor = 1'b0;
        repeat (n) @(negedge fab_clk);
        chk("rst_tap", cur_tap, LOAD_TAP);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_move", dly_move, 0);
        chk("rst_load", dly_load, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_dir", dly_dir, 0);
        sync_rst = 1'b0;
        ld_t = 0; rdy_t = 0; dn = 0;
        for (int t = 1; t <= 20 && rdy_t == 0; t++) begin
            @(negedge fab_clk);
            if (dly_load && ld_t == 0) ld_t = t;
            if (done) dn++;
            if (cmd_ready) rdy_t = t;
        end
        chk("init_load_cyc", ld_t, 1);
        chk("init_ready_cyc", rdy_t, MOVE_GAP + 2);
        chk("init_no_done", dn, 0);
        chk("init_tap", cur_tap, LOAD_TAP);
        mdl_tap = LOAD_TAP;
    endtask

    task automatic run_cmd(input int op, input int arg, input int oor_k, input int oor_off);
        int e_tap, e_mv, e_done, e_err, e_dir;
        int t, mv, pos_bad, dir_bad, done_t, ld_t, oor_at, w;
        logic done_err;
        logic [TAP_W-1:0] done_tap;
        model(mdl_tap, op, arg, oor_k, e_tap, e_mv, e_done, e_err, e_dir);
        w = 0;
        while (!cmd_ready && w < 100) begin @(negedge fab_clk); w++; end
        chk("ready_before", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op[1:0]; cmd_arg = arg[TAP_W-1:0]; oor = 1'b0;
        t = 0; mv = 0; pos_bad = 0; dir_bad = 0; done_t = 0; ld_t = 0; oor_at = -1;
        done_err = 1'b0; done_tap = '0;
        while (t < e_done + 10 && done_t == 0) begin
            @(negedge fab_clk);
            t++;
            // Command inputs scrambled while busy: must be neither re-accepted nor re-read.
            cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 2'($urandom); cmd_arg = TAP_W'($urandom);
            if (dly_move) begin
                mv++;
                if (t != 2 + (mv - 1) * PER) pos_bad++;
                if (dly_dir !== e_dir[0]) dir_bad++;
                if (mv == oor_k) oor_at = t + oor_off;
            end
            if (dly_load && ld_t == 0) ld_t = t;
            oor = (t == oor_at) || ((dly_move || t == 1) && $urandom_range(0, 1) == 1);
            if (done) begin done_t = t; done_err = err; done_tap = cur_tap; end
        end
        @(negedge fab_clk);
        cmd_valid = 1'b0; oor = 1'b0;
        chk("ready_after", cmd_ready, 1);
        chk("done_single", done, 0);
        chk("done_cyc", done_t, e_done);
        chk("done_err", done_err, e_err);
        chk("done_tap", done_tap, e_tap);
        chk("move_cnt", mv, e_mv);
        chk("move_pos_bad", pos_bad, 0);
        chk("move_dir_bad", dir_bad, 0);
        chk("load_cyc", ld_t, (op == 0) ? 1 : 0);
        mdl_tap = e_tap;
    endtask

    task automatic mid_reset();
        int mv, dn;
        mv = 0; dn = 0;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 8'd5;
        for (int t = 1; t <= 9; t++) begin
            @(negedge fab_clk);
            cmd_valid = 1'b0;
            if (dly_move) mv++;
            if (done) dn++;
        end
        chk("mid_moves", mv, 2);
        do_reset(1);
        chk("mid_no_done", dn, 0);
    endtask

    initial begin
        int op, arg, k, off;
        do_reset(3);
        run_cmd(1, 3, 0, 0);
        run_cmd(2, 10, 0, 0);
        run_cmd(3, 250, 0, 0);
        run_cmd(3, 255, 3, 2);
        run_cmd(3, 0, 0, 0);
        run_cmd(3, 0, 0, 0);
        run_cmd(3, 40, 0, 0);
        run_cmd(0, 0, 0, 0);
        mid_reset();
        run_cmd(1, 2, 0, 0);
        run_cmd(3, 255, 0, 0);
        run_cmd(1, 7, 0, 0);
        repeat (40) begin
            op  = $urandom_range(0, 3);
            arg = (op == 3 || $urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            k   = (op != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            off = $urandom_range(1, MOVE_GAP);
            run_cmd(op, arg, k, off);
        end
        chk("mv_ld_overlap", overlap_cnt, 0);
        chk("pulse_spacing", spacing_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
